// File: rtl/unidad_control_bip.sv
// unidad_control_bip: control unit for the 16-bit accumulator datapath.
// Holds the program counter and decodes the current instruction word into
// operand-mux, accumulator, ALU and data-memory controls.
// Optional build macro UNIDAD_CONTROL_CICLOS_EN adds the Ciclos counter of
// edges spent executing (HLT cycle included), saturating, held in HALT.
module unidad_control_bip #(
    parameter int ANCHO_PC   = 11,
    parameter int ANCHO_DATO = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [ANCHO_DATO-1:0] Instruccion,
    output logic [ANCHO_PC-1:0]   DirPrograma,
    output logic [ANCHO_PC-1:0]   DirDatos,
    output logic [ANCHO_DATO-1:0] Inmediato,
    output logic                  SelB,
    output logic [1:0]            SelA,
    output logic                  WrAcc,
    output logic                  Op,
    output logic                  WrRam,
    output logic                  RdRam,
    output logic                  Ocupado,
`ifdef UNIDAD_CONTROL_CICLOS_EN
    output logic [ANCHO_DATO-1:0] Ciclos,
`endif
    output logic                  Halt
);

    localparam int ANCHO_OP = ANCHO_DATO - ANCHO_PC;

    localparam logic [ANCHO_OP-1:0] OP_HLT  = ANCHO_OP'(0);
    localparam logic [ANCHO_OP-1:0] OP_STO  = ANCHO_OP'(1);
    localparam logic [ANCHO_OP-1:0] OP_LD   = ANCHO_OP'(2);
    localparam logic [ANCHO_OP-1:0] OP_LDI  = ANCHO_OP'(3);
    localparam logic [ANCHO_OP-1:0] OP_ADD  = ANCHO_OP'(4);
    localparam logic [ANCHO_OP-1:0] OP_ADDI = ANCHO_OP'(5);
    localparam logic [ANCHO_OP-1:0] OP_SUB  = ANCHO_OP'(6);
    localparam logic [ANCHO_OP-1:0] OP_SUBI = ANCHO_OP'(7);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EJEC = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t                state, state_next;
    logic [ANCHO_PC-1:0]   pc, pc_next;
    logic [ANCHO_OP-1:0]   opcode;

    assign opcode      = Instruccion[ANCHO_DATO-1:ANCHO_PC];
    assign DirPrograma = pc;

    // Operand fields are pure wiring and follow the instruction word in every state.
    assign DirDatos  = Instruccion[ANCHO_PC-1:0];
    assign Inmediato = {{ANCHO_OP{Instruccion[ANCHO_PC-1]}}, Instruccion[ANCHO_PC-1:0]};

    assign Ocupado = (state == EJEC);
    assign Halt    = (state == HALT);

    // State and program counter; reset drops everything to IDLE at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next state, next PC and the decoded controls, all qualified by EJEC so a
    // reset mid-instruction removes the write enables before the next edge.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        SelB       = 1'b0;
        SelA       = 2'b00;
        WrAcc      = 1'b0;
        Op         = 1'b0;
        WrRam      = 1'b0;
        RdRam      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_next = EJEC;
            end
            EJEC: begin
                // PC wraps naturally at 2^ANCHO_PC; HLT is the only word that freezes it.
                pc_next = pc + 1'b1;
                case (opcode)
                    OP_HLT: begin
                        pc_next    = pc;
                        state_next = HALT;
                    end
                    OP_STO: WrRam = 1'b1;
                    OP_LD: begin
                        RdRam = 1'b1;
                        WrAcc = 1'b1;
                    end
                    OP_LDI: begin
                        SelB  = 1'b1;
                        WrAcc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        RdRam = 1'b1;
                        SelA  = 2'b01;
                        Op    = (opcode == OP_SUB);
                        WrAcc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        SelB  = 1'b1;
                        SelA  = 2'b01;
                        Op    = (opcode == OP_SUBI);
                        WrAcc = 1'b1;
                    end
                    default: ; // undefined opcode behaves as NOP
                endcase
            end
            HALT: ; // terminal until reset
            default: state_next = IDLE;
        endcase
    end

`ifdef UNIDAD_CONTROL_CICLOS_EN
    // Executed-cycle counter: one per edge in EJEC, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Ciclos <= '0;
        end else if (state == EJEC && Ciclos != '1) begin
            Ciclos <= Ciclos + 1'b1;
        end
    end
`endif

endmodule
